// File: rtl/spu_ldreq_arb_pkg.sv
// Shared definitions for the SPU L2 load-request arbiter.
// One-hot state indices and the default watchdog length.
package spu_ldreq_arb_pkg;

  localparam int ST_IDLE  = 0;
  localparam int ST_REQ   = 1;
  localparam int ST_WAIT  = 2;
  localparam int ST_DRAIN = 3;

  localparam int TO_CYC_DEF = 255;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    REQ   = 4'b0010,
    WAIT  = 4'b0100,
    DRAIN = 4'b1000
  } ldreq_state_t;

endpackage

// File: rtl/spu_ldreq_arb_rr.sv
// Two-way round-robin picker for the load-request arbiter.
// When both requesters are eligible, the one pointed at by rr_ptr wins.
module spu_ldreq_arb_rr
  import spu_ldreq_arb_pkg::*;
(
  input  logic       rclk,
  input  logic       rst_l,
  input  logic       se,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       winner
);

  logic rr_ptr;
  logic unused_se;

  // No scan-muxed flops are instantiated here; se is only carried through.
  assign unused_se = se;

  assign winner = (&req) ? rr_ptr : req[1];

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~winner;
    end
  end

endmodule

// File: rtl/spu_ldreq_arb.sv
// Shares the SPU L2 load-request path between two requesters, with one load
// outstanding at a time, abort/drain handling and a watchdog.
//
// state | meaning
// IDLE  | no load in flight; grants the next eligible requester
// REQ   | spu_ldreq driven, waiting for the LSU to accept it
// WAIT  | load accepted, waiting for the line return for the owner
// DRAIN | owner aborted after accept; swallow the orphaned line return
module spu_ldreq_arb
  import spu_ldreq_arb_pkg::*;
#(
  parameter int              TO_W   = 8,
  parameter logic [TO_W-1:0] TO_CYC = TO_W'(TO_CYC_DEF)
) (
  input  logic rclk,
  input  logic rst_l,
  input  logic se,
  input  logic req0,
  input  logic req1,
  input  logic abort0,
  input  logic abort1,
  input  logic lsu_ldreq_ack,
  input  logic lsu_ln_received,
  output logic spu_ldreq,
  output logic ack0,
  output logic ack1,
  output logic ln0,
  output logic ln1,
  output logic owner,
  output logic busy,
  output logic timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - 1'b1;

  ldreq_state_t    state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      req_m;
  logic            grant;
  logic            winner;
  logic            own_abort;
  logic            to_hit;

  assign req_m     = {req1 & ~abort1, req0 & ~abort0};
  assign grant     = state[ST_IDLE] & (|req_m);
  assign own_abort = owner ? abort1 : abort0;
  // A line arriving on the expiry cycle wins over the timeout.
  assign to_hit    = (state[ST_WAIT] | state[ST_DRAIN]) & (cnt == TO_LAST) & ~lsu_ln_received;

  spu_ldreq_arb_rr u_rr (
    .rclk   (rclk),
    .rst_l  (rst_l),
    .se     (se),
    .req    (req_m),
    .accept (grant),
    .winner (winner)
  );

  assign spu_ldreq = state[ST_REQ];
  assign ack0      = state[ST_REQ] & lsu_ldreq_ack & ~owner;
  assign ack1      = state[ST_REQ] & lsu_ldreq_ack & owner;
  assign ln0       = state[ST_WAIT] & lsu_ln_received & ~owner;
  assign ln1       = state[ST_WAIT] & lsu_ln_received & owner;
  assign busy      = ~state[ST_IDLE];
  assign timeout   = to_hit;

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state <= IDLE;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= REQ;
            owner <= winner;
          end
        end
        REQ: begin
          if (lsu_ldreq_ack) begin
            state <= own_abort ? DRAIN : WAIT;
            cnt   <= '0;
          end else if (own_abort) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lsu_ln_received || to_hit) begin
            state <= IDLE;
          end else if (own_abort) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (lsu_ln_received || to_hit) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_ldreq_arb.sv
// Self-checking bench for spu_ldreq_arb: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_spu_ldreq_arb;

  localparam int TB_TO = 4;

  logic rclk = 1'b0;
  logic rst_l, se;
  logic req0, req1, abort0, abort1, lsu_ldreq_ack, lsu_ln_received;
  logic spu_ldreq, ack0, ack1, ln0, ln1, owner, busy, timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: which requester holds the path, whether its load was
  // accepted, whether its return is orphaned, and cycles waited since accept.
  int m_cur;
  bit m_issued, m_orphan, m_pref, m_owner;
  int m_wait;

  always #5 rclk = ~rclk;

  spu_ldreq_arb #(.TO_W(8), .TO_CYC(8'(TB_TO))) dut (
    .rclk            (rclk),
    .rst_l           (rst_l),
    .se              (se),
    .req0            (req0),
    .req1            (req1),
    .abort0          (abort0),
    .abort1          (abort1),
    .lsu_ldreq_ack   (lsu_ldreq_ack),
    .lsu_ln_received (lsu_ln_received),
    .spu_ldreq       (spu_ldreq),
    .ack0            (ack0),
    .ack1            (ack1),
    .ln0             (ln0),
    .ln1             (ln1),
    .owner           (owner),
    .busy            (busy),
    .timeout         (timeout)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_issued = 0; m_orphan = 0; m_pref = 0; m_owner = 0; m_wait = 0;
  endtask

  task automatic model_check();
    bit idle, e_req, e_live, e_to;
    idle   = (m_cur < 0);
    e_req  = !idle && !m_issued;
    e_live = !idle && m_issued && !m_orphan;
    e_to   = !idle && m_issued && (m_wait == TB_TO - 1) && !lsu_ln_received;
    chk("m_spu_ldreq", spu_ldreq, e_req);
    chk("m_ack0", ack0, e_req && lsu_ldreq_ack && m_cur == 0);
    chk("m_ack1", ack1, e_req && lsu_ldreq_ack && m_cur == 1);
    chk("m_ln0", ln0, e_live && lsu_ln_received && m_cur == 0);
    chk("m_ln1", ln1, e_live && lsu_ln_received && m_cur == 1);
    chk("m_owner", owner, m_owner);
    chk("m_busy", busy, !idle);
    chk("m_timeout", timeout, e_to);
  endtask

  task automatic model_update();
    bit e0, e1, own_ab;
    int w;
    if (m_cur < 0) begin
      e0 = req0 && !abort0;
      e1 = req1 && !abort1;
      if (e0 || e1) begin
        w = (e0 && e1) ? int'(m_pref) : (e1 ? 1 : 0);
        m_cur = w; m_owner = (w == 1); m_pref = (w == 0);
        m_issued = 0; m_orphan = 0;
      end
    end else begin
      own_ab = (m_cur == 1) ? abort1 : abort0;
      if (!m_issued) begin
        if (lsu_ldreq_ack) begin
          m_issued = 1; m_wait = 0; m_orphan = own_ab;
        end else if (own_ab) begin
          m_cur = -1;
        end
      end else if (lsu_ln_received || m_wait == TB_TO - 1) begin
        m_cur = -1;
      end else if (!m_orphan && own_ab) begin
        m_orphan = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  // Called just after a rising edge: apply inputs, settle, check against model.
  task automatic drive(input bit r0, input bit r1, input bit a0, input bit a1,
                       input bit ak, input bit ln);
    req0 = r0; req1 = r1; abort0 = a0; abort1 = a1;
    lsu_ldreq_ack = ak; lsu_ln_received = ln;
    #3;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge rclk); #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    req0 = 0; req1 = 0; abort0 = 0; abort1 = 0; lsu_ldreq_ack = 0; lsu_ln_received = 0;
    @(posedge rclk); #4;
    chk("rst_spu_ldreq", spu_ldreq, 1'b0);
    chk("rst_ack", ack0 | ack1, 1'b0);
    chk("rst_ln", ln0 | ln1, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst_l = 1'b1;
    model_reset();
    @(posedge rclk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL tb_time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit r0, r1, a0, a1, ak, ln;
    bit exp_own;
    rst_l = 1'b0; se = 1'b0;
    model_reset();
    do_reset();

    // Single request: grant at 0, ack at 3, line at 6.
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int c = 1; c <= 2; c++) begin
      drive(1, 0, 0, 0, 0, 0); chk("single_ldreq", spu_ldreq, 1'b1); tick();
    end
    drive(1, 0, 0, 0, 1, 0); chk("single_ack0", ack0, 1'b1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1); chk("single_ln0", ln0, 1'b1); tick();
    drive(0, 0, 0, 0, 0, 0); chk("single_busy", busy, 1'b0);
    chk("single_owner", owner, 1'b0); tick();

    // Contention: both requesting continuously, grants alternate from 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_own = (k % 2 == 1);
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 1, 0);
      chk("cont_owner", owner, exp_own);
      chk("cont_ack0", ack0, !exp_own);
      chk("cont_ack1", ack1, exp_own);
      tick();
      drive(1, 1, 0, 0, 0, 1);
      chk("cont_ln0", ln0, !exp_own);
      chk("cont_ln1", ln1, exp_own);
      tick();
    end

    // Abort before ack by owner 1 with req0 pending.
    do_reset();
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); chk("abrt_owner1", owner, 1'b1); tick();
    drive(1, 0, 0, 1, 0, 0); chk("abrt_no_ack1", ack1, 1'b0); tick();
    drive(1, 0, 0, 0, 0, 0); chk("abrt_ldreq_drop", spu_ldreq, 1'b0);
    chk("abrt_idle", busy, 1'b0); tick();
    drive(0, 0, 0, 0, 1, 0); chk("abrt_regrant", spu_ldreq, 1'b1);
    chk("abrt_owner0", owner, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 1); tick();

    // Abort together with ack: ack forwarded, then drain the return.
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 0); chk("drain_ack1", ack1, 1'b1); tick();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 0, 0, 0); chk("drain_no_ldreq", spu_ldreq, 1'b0);
      chk("drain_busy", busy, 1'b1); tick();
    end
    drive(1, 0, 0, 0, 0, 1); chk("drain_ln1", ln1, 1'b0); chk("drain_ln0", ln0, 1'b0); tick();
    drive(1, 0, 0, 0, 0, 0); chk("drain_idle", busy, 1'b0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1); tick();

    // Watchdog: timeout on the 4th cycle after the ack, then line on that cycle.
    for (int rep = 0; rep < 2; rep++) begin
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      for (int c = 0; c < 3; c++) begin
        drive(0, 0, 0, 0, 0, 0); chk("wd_early", timeout, 1'b0); tick();
      end
      if (rep == 0) begin
        drive(0, 0, 0, 0, 0, 0); chk("wd_fire", timeout, 1'b1); tick();
      end else begin
        drive(0, 0, 0, 0, 0, 1); chk("wd_ln_prio", timeout, 1'b0);
        chk("wd_ln0", ln0, 1'b1); tick();
      end
      drive(0, 0, 0, 0, 0, 0); chk("wd_idle", busy, 1'b0); tick();
    end

    // Reset mid-WAIT, stray line afterwards, rr pointer back to 0.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0); chk("mid_wait_busy", busy, 1'b1); tick();
    do_reset();
    drive(0, 0, 0, 0, 0, 1); chk("stray_ln", ln0 | ln1, 1'b0); tick();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); chk("rst_rr_owner", owner, 1'b0); tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(599) == 0) do_reset();
      r0 = ($urandom_range(1) == 1);
      r1 = ($urandom_range(1) == 1);
      a0 = ($urandom_range(7) == 0);
      a1 = ($urandom_range(7) == 0);
      ak = ($urandom_range(2) == 0);
      ln = ($urandom_range(3) == 0);
      drive(r0, r1, a0, a1, ak, ln);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
